// File: rtl/umi_arbmux.sv
// umi_arbmux: N-input UMI arbiter and multiplexer.
// Arbitration is round-robin (ROUNDROBIN=1) or fixed priority with the lowest
// index winning (ROUNDROBIN=0). The grant is held while the output is stalled.
// Optional macro UMI_ARBMUX_OUTREG_EN adds a registered output stage
// (latency 1, full throughput). Without it the output is combinational.
module umi_arbmux #(
  parameter int unsigned UW         = 256,
  parameter int unsigned CW         = 32,
  parameter int unsigned AW         = 64,
  parameter int unsigned N          = 4,
  parameter int unsigned ROUNDROBIN = 1
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dst_addr,
  input  logic [N*AW-1:0] umi_in_src_addr,
  input  logic [N*UW-1:0] umi_in_payload,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  input  logic            umi_out_ready,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dst_addr,
  output logic [AW-1:0]   umi_out_src_addr,
  output logic [UW-1:0]   umi_out_payload
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic          lock_q;
  logic [N-1:0]  lock_grant_q;
  logic [N-1:0]  arb_grant;
  logic [N-1:0]  grant;
  logic [PW-1:0] grant_idx;
  logic          arb_found;
  int unsigned   arb_idx;
  logic          stage_free;
  logic          in_hs;
  logic [CW-1:0] mux_cmd;
  logic [AW-1:0] mux_dst;
  logic [AW-1:0] mux_src;
  logic [UW-1:0] mux_payload;

  // Search from the pointer (or from 0 in fixed priority) for the first valid input
  always_comb begin
    arb_grant = '0;
    arb_found = 1'b0;
    arb_idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      arb_idx = (ROUNDROBIN != 0) ? ((32'(ptr_q) + k) % N) : k;
      if (!arb_found && umi_in_valid[PW'(arb_idx)]) begin
        arb_grant[PW'(arb_idx)] = 1'b1;
        arb_found               = 1'b1;
      end
    end
  end

  assign grant = lock_q ? lock_grant_q : arb_grant;

  // Encode the grant and select the granted input's fields
  always_comb begin
    grant_idx   = '0;
    mux_cmd     = '0;
    mux_dst     = '0;
    mux_src     = '0;
    mux_payload = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = PW'(i);
      mux_cmd     = mux_cmd     | (umi_in_cmd[i*CW +: CW]      & {CW{grant[i]}});
      mux_dst     = mux_dst     | (umi_in_dst_addr[i*AW +: AW] & {AW{grant[i]}});
      mux_src     = mux_src     | (umi_in_src_addr[i*AW +: AW] & {AW{grant[i]}});
      mux_payload = mux_payload | (umi_in_payload[i*UW +: UW]  & {UW{grant[i]}});
    end
  end

  assign umi_in_ready = grant & {N{stage_free & nreset}};
  assign in_hs        = |(umi_in_valid & umi_in_ready);

  // Priority pointer moves past the input that just handshook; lock holds grant during stalls
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr_q        <= '0;
      lock_q       <= 1'b0;
      lock_grant_q <= '0;
    end else begin
      if (in_hs) begin
        ptr_q <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
      end
      lock_q       <= umi_out_valid & ~umi_out_ready;
      lock_grant_q <= grant;
    end
  end

`ifdef UMI_ARBMUX_OUTREG_EN
  assign stage_free = ~umi_out_valid | umi_out_ready;

  // Output stage loads on input handshake and empties on output handshake
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      umi_out_valid    <= 1'b0;
      umi_out_cmd      <= '0;
      umi_out_dst_addr <= '0;
      umi_out_src_addr <= '0;
      umi_out_payload  <= '0;
    end else if (in_hs) begin
      umi_out_valid    <= 1'b1;
      umi_out_cmd      <= mux_cmd;
      umi_out_dst_addr <= mux_dst;
      umi_out_src_addr <= mux_src;
      umi_out_payload  <= mux_payload;
    end else if (umi_out_ready) begin
      umi_out_valid    <= 1'b0;
    end
  end
`else
  assign stage_free       = umi_out_ready;
  assign umi_out_valid    = (|umi_in_valid) & nreset;
  assign umi_out_cmd      = mux_cmd;
  assign umi_out_dst_addr = mux_dst;
  assign umi_out_src_addr = mux_src;
  assign umi_out_payload  = mux_payload;
`endif

endmodule

// File: tb/tb_umi_arbmux.sv
// tb_umi_arbmux: directed scoreboard bench for umi_arbmux. Three instances:
// round-robin N=4, fixed-priority N=4 and round-robin N=16.
// Expectations follow UMI_ARBMUX_OUTREG_EN when it is defined.
module tb_umi_arbmux;

`ifdef UMI_ARBMUX_OUTREG_EN
  localparam int OV_FIRST = 0;
  localparam int OV_DRAIN = 1;
`else
  localparam int OV_FIRST = 1;
  localparam int OV_DRAIN = 0;
`endif

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  logic [3:0]   rr_valid, rr_ready;
  logic [31:0]  rr_cmd, rr_dst, rr_src;
  logic [63:0]  rr_pay;
  logic         rr_ovalid, rr_oready;
  logic [7:0]   rr_ocmd, rr_odst, rr_osrc;
  logic [15:0]  rr_opay;

  logic [3:0]   fp_valid, fp_ready;
  logic [31:0]  fp_cmd, fp_dst, fp_src;
  logic [63:0]  fp_pay;
  logic         fp_ovalid, fp_oready;
  logic [7:0]   fp_ocmd, fp_odst, fp_osrc;
  logic [15:0]  fp_opay;

  logic [15:0]  w_valid, w_ready;
  logic [127:0] w_cmd, w_dst, w_src;
  logic [255:0] w_pay;
  logic         w_ovalid, w_oready;
  logic [7:0]   w_ocmd, w_odst, w_osrc;
  logic [15:0]  w_opay;

  logic [7:0] q_rr[$];
  logic [7:0] q_fp[$];
  logic [7:0] q_w[$];

  int vectors = 0;
  int errs    = 0;

  umi_arbmux #(.UW(16), .CW(8), .AW(8), .N(4), .ROUNDROBIN(1)) u_rr (
    .clk(clk), .nreset(nreset),
    .umi_in_valid(rr_valid), .umi_in_cmd(rr_cmd), .umi_in_dst_addr(rr_dst),
    .umi_in_src_addr(rr_src), .umi_in_payload(rr_pay), .umi_in_ready(rr_ready),
    .umi_out_valid(rr_ovalid), .umi_out_ready(rr_oready), .umi_out_cmd(rr_ocmd),
    .umi_out_dst_addr(rr_odst), .umi_out_src_addr(rr_osrc), .umi_out_payload(rr_opay)
  );

  umi_arbmux #(.UW(16), .CW(8), .AW(8), .N(4), .ROUNDROBIN(0)) u_fp (
    .clk(clk), .nreset(nreset),
    .umi_in_valid(fp_valid), .umi_in_cmd(fp_cmd), .umi_in_dst_addr(fp_dst),
    .umi_in_src_addr(fp_src), .umi_in_payload(fp_pay), .umi_in_ready(fp_ready),
    .umi_out_valid(fp_ovalid), .umi_out_ready(fp_oready), .umi_out_cmd(fp_ocmd),
    .umi_out_dst_addr(fp_odst), .umi_out_src_addr(fp_osrc), .umi_out_payload(fp_opay)
  );

  umi_arbmux #(.UW(16), .CW(8), .AW(8), .N(16), .ROUNDROBIN(1)) u_w (
    .clk(clk), .nreset(nreset),
    .umi_in_valid(w_valid), .umi_in_cmd(w_cmd), .umi_in_dst_addr(w_dst),
    .umi_in_src_addr(w_src), .umi_in_payload(w_pay), .umi_in_ready(w_ready),
    .umi_out_valid(w_ovalid), .umi_out_ready(w_oready), .umi_out_cmd(w_ocmd),
    .umi_out_dst_addr(w_odst), .umi_out_src_addr(w_osrc), .umi_out_payload(w_opay)
  );

  // One comparison: counted, and reported on mismatch
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop and compare every output handshake of every instance
  task automatic mon();
    if (rr_ovalid && rr_oready) begin
      if (q_rr.size() == 0) chk("rr_unexpected_out", 32'(rr_ovalid), 0);
      else chk("rr_out_cmd", 32'(rr_ocmd), 32'(q_rr.pop_front()));
    end
    if (fp_ovalid && fp_oready) begin
      if (q_fp.size() == 0) chk("fp_unexpected_out", 32'(fp_ovalid), 0);
      else chk("fp_out_cmd", 32'(fp_ocmd), 32'(q_fp.pop_front()));
    end
    if (w_ovalid && w_oready) begin
      if (q_w.size() == 0) chk("w_unexpected_out", 32'(w_ovalid), 0);
      else chk("w_out_cmd", 32'(w_ocmd), 32'(q_w.pop_front()));
    end
  endtask

  // One cycle on the round-robin instance: g = expected grant (-1 none), ov = expected out_valid (-1 skip)
  task automatic rr_cycle(input int g, input int ov);
    @(negedge clk);
    chk("rr_ready", 32'(rr_ready), (g < 0) ? 0 : (1 << g));
    if (ov >= 0) chk("rr_out_valid", 32'(rr_ovalid), 32'(ov));
    if (g >= 0) q_rr.push_back(rr_cmd[g*8 +: 8]);
    mon();
    @(posedge clk); #1;
  endtask

  task automatic fp_cycle(input int g);
    @(negedge clk);
    chk("fp_ready", 32'(fp_ready), (g < 0) ? 0 : (1 << g));
    if (g >= 0) q_fp.push_back(fp_cmd[g*8 +: 8]);
    mon();
    @(posedge clk); #1;
  endtask

  task automatic w_cycle(input int g);
    @(negedge clk);
    chk("w_ready", 32'(w_ready), (g < 0) ? 0 : (1 << g));
    if (g >= 0) q_w.push_back(w_cmd[g*8 +: 8]);
    mon();
    @(posedge clk); #1;
  endtask

  // Stalled cycle holding input 2's payload
  task automatic rr_stall();
    @(negedge clk);
    chk("rr_stall_ready", 32'(rr_ready), 0);
    chk("rr_stall_valid", 32'(rr_ovalid), 1);
    chk("rr_stall_pay", 32'(rr_opay), 32'h00A5);
    mon();
    @(posedge clk); #1;
  endtask

  initial begin
    nreset = 1'b0;
    rr_cmd = '0; rr_dst = '0; rr_src = '0; rr_pay = '0;
    fp_cmd = '0; fp_dst = '0; fp_src = '0; fp_pay = '0;
    w_cmd  = '0; w_dst  = '0; w_src  = '0; w_pay  = '0;
    for (int i = 0; i < 4; i++) begin
      rr_cmd[i*8 +: 8]  = 8'(8'h10 + i);
      rr_dst[i*8 +: 8]  = 8'(8'h80 + i);
      rr_src[i*8 +: 8]  = 8'(8'hC0 + i);
      rr_pay[i*16 +: 16] = 16'(16'h0100 + i);
      fp_cmd[i*8 +: 8]  = 8'(8'h20 + i);
    end
    for (int i = 0; i < 16; i++) w_cmd[i*8 +: 8] = 8'(8'h40 + i);
    rr_valid = 4'b1111; fp_valid = 4'b1111; w_valid = '1;
    rr_oready = 1'b1; fp_oready = 1'b1; w_oready = 1'b1;

    // Reset state: no ready, no output valid even with inputs requesting
    repeat (2) @(negedge clk);
    chk("rst_rr_ready", 32'(rr_ready), 0);
    chk("rst_rr_ovalid", 32'(rr_ovalid), 0);
    chk("rst_fp_ready", 32'(fp_ready), 0);
    chk("rst_w_ready", 32'(w_ready), 0);
`ifdef UMI_ARBMUX_OUTREG_EN
    chk("rst_rr_ocmd", 32'(rr_ocmd), 0);
    chk("rst_rr_opay", 32'(rr_opay), 0);
`endif
    rr_valid = '0; fp_valid = '0; w_valid = '0;
    @(posedge clk); #1;
    nreset = 1'b1;

    // All four valid: grants 0,1,2,3,0,1,2,3
    rr_valid = 4'b1111;
    for (int k = 0; k < 8; k++) rr_cycle(k % 4, (k == 0) ? OV_FIRST : 1);
    rr_valid = '0;
    rr_cycle(-1, OV_DRAIN);

    // Stall on input 2 (payload A5) while input 0 requests
    rr_pay[2*16 +: 16] = 16'h00A5;
    rr_valid  = 4'b0100;
    rr_oready = 1'b0;
`ifdef UMI_ARBMUX_OUTREG_EN
    rr_cycle(2, 0);
    rr_valid = 4'b0001;
    repeat (5) rr_stall();
    rr_oready = 1'b1;
    rr_cycle(0, 1);
    rr_valid = '0;
    rr_cycle(-1, 1);
`else
    for (int k = 0; k < 5; k++) begin
      if (k == 1) rr_valid = 4'b0101;
      rr_stall();
    end
    rr_oready = 1'b1;
    rr_cycle(2, 1);
    rr_valid = 4'b0001;
    rr_cycle(0, 1);
    rr_valid = '0;
    rr_cycle(-1, 0);
`endif

    // Move pointer to 3, stall, then pulse reset
`ifdef UMI_ARBMUX_OUTREG_EN
    rr_valid  = 4'b0100;
    rr_oready = 1'b0;
    rr_cycle(2, 0);
    rr_valid = 4'b1001;
    rr_cycle(-1, 1);
    rr_cycle(-1, 1);
`else
    rr_valid = 4'b0100;
    rr_cycle(2, 1);
    rr_valid = '0;
    rr_cycle(-1, 0);
    rr_valid  = 4'b1001;
    rr_oready = 1'b0;
    rr_cycle(-1, 1);
    rr_cycle(-1, 1);
    chk("rr_stall_cmd", 32'(rr_ocmd), 32'h13);
`endif
    nreset = 1'b0;
    #2;
    chk("midrst_ovalid", 32'(rr_ovalid), 0);
    chk("midrst_ready", 32'(rr_ready), 0);
    q_rr.delete();
    @(negedge clk);
    chk("midrst_ready_hold", 32'(rr_ready), 0);
    @(posedge clk); #1;
    nreset    = 1'b1;
    rr_oready = 1'b1;
    rr_cycle(0, OV_FIRST);
    rr_valid = '0;
    rr_cycle(-1, OV_DRAIN);

    // Single-input stream of cmd 1..10 at full rate
    rr_valid = 4'b0010;
    for (int k = 1; k <= 10; k++) begin
      rr_cmd[8 +: 8] = 8'(k);
      rr_cycle(1, (k == 1) ? OV_FIRST : 1);
    end
    rr_valid = '0;
    rr_cycle(-1, OV_DRAIN);

    // Fixed priority: lowest valid index always wins
    fp_valid = 4'b1010;
    repeat (4) fp_cycle(1);
    fp_valid = 4'b1100;
    fp_cycle(2);
    fp_valid = 4'b1000;
    fp_cycle(3);
    fp_valid = 4'b1111;
    fp_cycle(0);
    fp_cycle(0);
    fp_valid = '0;
    fp_cycle(-1);

    // N=16 wrap-around: inputs 0 and 15 alternate
    w_valid = 16'h8001;
    w_cycle(0);
    w_cycle(15);
    w_cycle(0);
    w_cycle(15);
    w_valid = '0;
    w_cycle(-1);

    // Every expected transfer must have come out
    chk("rr_q_empty", 32'(q_rr.size()), 0);
    chk("fp_q_empty", 32'(q_fp.size()), 0);
    chk("w_q_empty", 32'(q_w.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
